// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter: FSM states,
// grant identities, default watchdog length and the round-robin pick.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IFETCH = 2'd1,
        ST_DATA   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } grant_e;

    localparam int DEFAULT_TIMEOUT = 64;

    // On a tie the requester that was not served last wins.
    function automatic grant_e pick_grant(input logic   if_req,
                                          input logic   d_req,
                                          input grant_e last_grant);
        grant_e pick;
        if (if_req && d_req) begin
            pick = (last_grant == GNT_D) ? GNT_IF : GNT_D;
        end else if (d_req) begin
            pick = GNT_D;
        end else begin
            pick = GNT_IF;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Transaction watchdog: cleared when a grant is issued, counts cycles without
// mem_ack and flags expiry once TIMEOUT-1 idle cycles have elapsed.
module mem_arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (run && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = run && (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store.
// Optional watchdog abort is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ready,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_byte_en,
    output logic                d_ready,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_byte_en,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic                err
);

    localparam int BE_W = DATA_W / 8;

    state_e            state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    grant_e            gnt_q, gnt_d;
    grant_e            arb_pick;

    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]   mem_byte_en_q, mem_byte_en_d;

    logic              if_ready_q, if_ready_d;
    logic              d_ready_q, d_ready_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] resp_data;
    logic              timeout_hit;

    assign arb_pick = pick_grant(if_req, d_req, last_grant_q);

`ifdef MEM_ARB_TIMEOUT_EN
    logic wd_start;
    logic wd_run;

    assign wd_start = (state_q == ST_IDLE) && (if_req || d_req);
    assign wd_run   = ((state_q == ST_IFETCH) || (state_q == ST_DATA)) && !mem_ack;

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (wd_start),
        .run     (wd_run),
        .expired (timeout_hit)
    );
`else
    // Without the watchdog the port waits for mem_ack forever and err stays low.
    logic unused_timeout;
    assign timeout_hit    = 1'b0;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        gnt_d         = gnt_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_byte_en_d = mem_byte_en_q;
        if_rdata_d    = if_rdata_q;
        d_rdata_d     = d_rdata_q;
        if_ready_d    = 1'b0;
        d_ready_d     = 1'b0;
        err_d         = 1'b0;
        resp_data     = mem_ack ? mem_rdata : '0;

        case (state_q)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    gnt_d     = arb_pick;
                    mem_req_d = 1'b1;
                    if (arb_pick == GNT_IF) begin
                        state_d       = ST_IFETCH;
                        mem_we_d      = 1'b0;
                        mem_addr_d    = if_addr;
                        mem_wdata_d   = '0;
                        mem_byte_en_d = '1;
                    end else begin
                        state_d       = ST_DATA;
                        mem_we_d      = d_we;
                        mem_addr_d    = d_addr;
                        mem_wdata_d   = d_we ? d_wdata : '0;
                        mem_byte_en_d = d_we ? d_byte_en : '1;
                    end
                end
            end

            ST_IFETCH, ST_DATA: begin
                // An ack always wins over a simultaneous watchdog expiry.
                if (mem_ack || timeout_hit) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_RESP;
                    err_d     = !mem_ack;
                    if (gnt_q == GNT_IF) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = resp_data;
                    end else begin
                        d_ready_d = 1'b1;
                        d_rdata_d = mem_we_q ? '0 : resp_data;
                    end
                end
            end

            ST_RESP: begin
                last_grant_d = gnt_q;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= GNT_D;
            gnt_q         <= GNT_IF;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_byte_en_q <= '0;
            if_ready_q    <= 1'b0;
            d_ready_q     <= 1'b0;
            if_rdata_q    <= '0;
            d_rdata_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            gnt_q         <= gnt_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_byte_en_q <= mem_byte_en_d;
            if_ready_q    <= if_ready_d;
            d_ready_q     <= d_ready_d;
            if_rdata_q    <= if_rdata_d;
            d_rdata_q     <= d_rdata_d;
            err_q         <= err_d;
        end
    end

    assign if_ready    = if_ready_q;
    assign if_rdata    = if_rdata_q;
    assign d_ready     = d_ready_q;
    assign d_rdata     = d_rdata_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_byte_en = mem_byte_en_q;
    assign busy        = (state_q != ST_IDLE);
    assign err         = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int AW          = 32;
    localparam int DW          = 32;
    localparam int BW          = DW / 8;
    localparam int TB_TIMEOUT  = 8;
    localparam int RAND_CYCLES = 3000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ready;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [BW-1:0] d_byte_en = '0;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_byte_en;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;
    logic          err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_ready    (if_ready),
        .if_rdata    (if_rdata),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_byte_en   (d_byte_en),
        .d_ready     (d_ready),
        .d_rdata     (d_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_byte_en (mem_byte_en),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .err         (err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string         name;
        bit            is_d;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
        int            lat;
        logic [DW-1:0] rdata;
        bit            exp_we;
        logic [BW-1:0] exp_be;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk_vec(string n, bit is_d, bit we, logic [AW-1:0] addr,
                                    logic [DW-1:0] wdata, logic [BW-1:0] be, int lat,
                                    logic [DW-1:0] rdata, bit exp_we, logic [BW-1:0] exp_be,
                                    logic [DW-1:0] exp_data);
        vec_t v;
        v.name = n; v.is_d = is_d; v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
        v.lat = lat; v.rdata = rdata; v.exp_we = exp_we; v.exp_be = exp_be; v.exp_data = exp_data;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_byte_en = v.be;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        @(posedge clk); #1;
        chk($sformatf("%s.mem_req", v.name), mem_req, 1);
        chk($sformatf("%s.busy", v.name), busy, 1);
        chk($sformatf("%s.mem_addr", v.name), mem_addr, v.addr);
        chk($sformatf("%s.mem_we", v.name), mem_we, v.exp_we);
        chk($sformatf("%s.mem_byte_en", v.name), mem_byte_en, v.exp_be);
        if (v.we) chk($sformatf("%s.mem_wdata", v.name), mem_wdata, v.wdata);
        for (int i = 1; i < v.lat; i++) begin
            @(posedge clk); #1;
            chk($sformatf("%s.req_held", v.name), {mem_req, mem_addr}, {1'b1, v.addr});
            chk($sformatf("%s.no_early_ready", v.name), {if_ready, d_ready}, 2'b00);
        end
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = v.rdata;
        @(posedge clk); #1;
        chk($sformatf("%s.req_cleared", v.name), mem_req, 0);
        chk($sformatf("%s.ready", v.name), {if_ready, d_ready}, v.is_d ? 2'b01 : 2'b10);
        chk($sformatf("%s.rdata", v.name), v.is_d ? d_rdata : if_rdata, v.exp_data);
        $display("txn %s: %s addr=0x%08h we=%0d be=0x%h rdata=0x%08h",
                 v.name, v.is_d ? "data" : "fetch", v.addr, v.we, mem_byte_en,
                 v.is_d ? d_rdata : if_rdata);
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = '0; if_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("%s.ready_one_cycle", v.name), {if_ready, d_ready}, 2'b00);
        chk($sformatf("%s.idle", v.name), busy, 0);
        chk($sformatf("%s.rdata_hold", v.name), v.is_d ? d_rdata : if_rdata, v.exp_data);
    endtask

    // ---------------- randomized phase ----------------
    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
    } dreq_t;

    logic [AW-1:0] if_q[$];
    dreq_t         d_q[$];

    task automatic if_requester(input int cycles);
        bit active = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (active && if_ready) begin active = 1'b0; if_req = 1'b0; end
            if (!active && c < cycles - 60 && $urandom_range(0, 2) == 0) begin
                if_addr = $urandom & 32'hFFFF_FFFC;
                if_req  = 1'b1; active = 1'b1;
                if_q.push_back(if_addr);
            end
        end
        if_req = 1'b0;
    endtask

    task automatic d_requester(input int cycles);
        bit    active = 1'b0;
        dreq_t r;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (active && d_ready) begin active = 1'b0; d_req = 1'b0; end
            if (!active && c < cycles - 60 && $urandom_range(0, 2) == 0) begin
                r.we = 1'($urandom_range(0, 1)); r.addr = $urandom; r.wdata = $urandom;
                r.be = 4'($urandom_range(1, 15));
                d_we = r.we; d_addr = r.addr; d_wdata = r.wdata; d_byte_en = r.be;
                d_req = 1'b1; active = 1'b1;
                d_q.push_back(r);
            end
        end
        d_req = 1'b0;
    endtask

    task automatic mem_responder(input int cycles);
        int lat_left = -1;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req) begin
                if (lat_left < 0) lat_left = int'($urandom_range(0, 3));
                if (lat_left == 0) begin
                    mem_ack = 1'b1; mem_rdata = $urandom; lat_left = -1;
                end else begin
                    lat_left--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                // stray ack while no transaction is outstanding
                mem_ack = 1'b1; mem_rdata = $urandom;
            end
        end
        mem_ack = 1'b0;
    endtask

    // Reference: one outstanding transaction, an idle cycle of response after
    // each completion, ties go to whoever was not served last.
    task automatic monitor(input int cycles);
        bit            txn_active = 1'b0, in_resp = 1'b0, gnt_d = 1'b0, last_d = 1'b1;
        bit            exp_ifr, exp_dr, e_we = 1'b0;
        logic [AW-1:0] e_addr = '0;
        logic [DW-1:0] e_wdata = '0, e_if_rdata = '0, e_d_rdata = '0;
        logic [BW-1:0] e_be = '0;
        int            n_txn = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            exp_ifr = 1'b0; exp_dr = 1'b0;
            if (txn_active) begin
                if (mem_ack) begin
                    txn_active = 1'b0; in_resp = 1'b1; last_d = gnt_d; n_txn++;
                    if (gnt_d) begin
                        exp_dr = 1'b1; e_d_rdata = e_we ? 32'h0 : mem_rdata;
                        if (d_q.size() > 0) void'(d_q.pop_front());
                    end else begin
                        exp_ifr = 1'b1; e_if_rdata = mem_rdata;
                        if (if_q.size() > 0) void'(if_q.pop_front());
                    end
                    $display("rand txn %0d: %s addr=0x%08h we=%0d data=0x%08h", n_txn,
                             gnt_d ? "data" : "fetch", e_addr, e_we, gnt_d ? e_d_rdata : e_if_rdata);
                end
            end else if (in_resp) begin
                in_resp = 1'b0;
            end else if (if_req || d_req) begin
                gnt_d = (if_req && d_req) ? !last_d : d_req;
                txn_active = 1'b1;
                if (gnt_d && d_q.size() > 0) begin
                    e_addr = d_q[0].addr; e_we = d_q[0].we; e_wdata = d_q[0].wdata;
                    e_be = d_q[0].we ? d_q[0].be : 4'hF;
                end else if (!gnt_d && if_q.size() > 0) begin
                    e_addr = if_q[0]; e_we = 1'b0; e_be = 4'hF;
                end
            end
            chk("rand.mem_req", mem_req, txn_active);
            chk("rand.busy", busy, txn_active || in_resp);
            chk("rand.if_ready", if_ready, exp_ifr);
            chk("rand.d_ready", d_ready, exp_dr);
            chk("rand.if_rdata", if_rdata, e_if_rdata);
            chk("rand.d_rdata", d_rdata, e_d_rdata);
            chk("rand.err", err, 0);
            if (txn_active) begin
                chk("rand.mem_addr", mem_addr, e_addr);
                chk("rand.mem_we", mem_we, e_we);
                chk("rand.mem_byte_en", mem_byte_en, e_be);
                if (e_we) chk("rand.mem_wdata", mem_wdata, e_wdata);
            end
        end
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1, "global timeout");
    end

    initial begin
        int            waited;
        logic [AW-1:0] tie_exp[4];

        vecs[0] = mk_vec("fetch10",   0, 0, 32'h10,       32'h0,        4'h0, 2, 32'h00940333, 0, 4'hF, 32'h00940333);
        vecs[1] = mk_vec("store20",   1, 1, 32'h20,       32'hDEADBEEF, 4'h3, 2, 32'h12345678, 1, 4'h3, 32'h0);
        vecs[2] = mk_vec("load24",    1, 0, 32'h24,       32'h11111111, 4'h5, 1, 32'hCAFEF00D, 0, 4'hF, 32'hCAFEF00D);
        vecs[3] = mk_vec("fetchtop",  0, 0, 32'hFFFFFFFC, 32'h0,        4'h0, 1, 32'hFFFFFFFF, 0, 4'hF, 32'hFFFFFFFF);
        vecs[4] = mk_vec("storefull", 1, 1, 32'h0,        32'h0,        4'hF, 5, 32'hAAAA5555, 1, 4'hF, 32'h0);
        vecs[5] = mk_vec("loadslow",  1, 0, 32'h1000,     32'h0,        4'h0, 6, 32'h0BADF00D, 0, 4'hF, 32'h0BADF00D);

        // reset state
        repeat (2) @(negedge clk);
        chk("reset.ctrl", {mem_req, mem_we, busy, err, if_ready, d_ready}, 6'b0);
        chk("reset.mem_addr", mem_addr, 0);
        chk("reset.mem_wdata", mem_wdata, 0);
        chk("reset.mem_byte_en", mem_byte_en, 0);
        chk("reset.rdata", {if_rdata, d_rdata}, 64'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // ties after reset: fetch first, then alternate
        do_reset();
        tie_exp[0] = 32'h100; tie_exp[1] = 32'h200; tie_exp[2] = 32'h100; tie_exp[3] = 32'h200;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_byte_en = '0;
        for (int g = 0; g < 4; g++) begin
            waited = 0;
            do begin @(posedge clk); #1; waited++; end while (!mem_req && waited < 10);
            chk($sformatf("tie%0d.granted", g), mem_req, 1);
            chk($sformatf("tie%0d.grant_addr", g), mem_addr, tie_exp[g]);
            @(negedge clk);
            mem_ack = 1'b1; mem_rdata = 32'hA000 + 32'(g);
            @(posedge clk); #1;
            chk($sformatf("tie%0d.ready", g), {if_ready, d_ready}, (g % 2 == 0) ? 2'b10 : 2'b01);
            $display("txn tie%0d: granted addr=0x%08h", g, mem_addr);
            @(negedge clk);
            mem_ack = 1'b0;
            if (g == 3) begin if_req = 1'b0; d_req = 1'b0; end
        end
        @(posedge clk); #1;

        // data request arriving mid-fetch waits for the following IDLE
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h40;
        @(posedge clk); #1;
        chk("mid.fetch_addr", mem_addr, 32'h40);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h55AA; d_byte_en = 4'hC;
        repeat (2) begin
            @(posedge clk); #1;
            chk("mid.port_stable", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h40});
        end
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h1234;
        @(posedge clk); #1;
        chk("mid.if_ready", {if_ready, d_ready, mem_req}, 3'b100);
        @(negedge clk);
        mem_ack = 1'b0; if_req = 1'b0;
        @(posedge clk); #1;
        chk("mid.resp_no_grant", {mem_req, d_ready}, 2'b00);
        @(posedge clk); #1;
        chk("mid.data_grant", {mem_req, mem_we, mem_byte_en, mem_addr}, {1'b1, 1'b1, 4'hC, 32'h80});
        @(negedge clk);
        mem_ack = 1'b1;
        @(posedge clk); #1;
        chk("mid.d_ready", {d_ready, d_rdata}, {1'b1, 32'h0});
        $display("txn mid: fetch 0x40 then store 0x80");
        @(negedge clk);
        mem_ack = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;

        // reset asserted while a load is outstanding
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        @(posedge clk); #1;
        chk("rstmid.granted", {mem_req, busy}, 2'b11);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rstmid.ctrl", {mem_req, busy, mem_we, err, if_ready, d_ready}, 6'b0);
        chk("rstmid.mem_addr", mem_addr, 0);
        chk("rstmid.mem_byte_en", mem_byte_en, 0);
        chk("rstmid.if_rdata", if_rdata, 0);
        d_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rstmid.no_ready", {d_ready, mem_req}, 2'b00);
        end
        run_vec(vecs[2]);

`ifdef MEM_ARB_TIMEOUT_EN
        begin : timeout_test
            int hi;
            bit done;
            hi = 0; done = 1'b0;
            @(negedge clk);
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
            for (int i = 0; i < 20 && !done; i++) begin
                @(posedge clk); #1;
                if (mem_req) hi++;
                else done = 1'b1;
            end
            chk("timeout.req_cycles", hi, TB_TIMEOUT);
            chk("timeout.ready_err", {d_ready, err, if_ready}, 3'b110);
            chk("timeout.d_rdata", d_rdata, 0);
            $display("txn timeout: load 0x400 aborted after %0d cycles", hi);
            @(negedge clk);
            d_req = 1'b0;
            @(posedge clk); #1;
            chk("timeout.err_pulse", {err, d_ready}, 2'b00);
        end
`endif

        // randomized run against the reference model
        do_reset();
        fork
            if_requester(RAND_CYCLES);
            d_requester(RAND_CYCLES);
            mem_responder(RAND_CYCLES);
            monitor(RAND_CYCLES);
        join
        chk("rand.if_drained", if_q.size(), 0);
        chk("rand.d_drained", d_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
